// File: rtl/kernel_window_ctrl.sv
// rtl/kernel_window_ctrl.sv - frame/line/pixel sequencer for the KxK line-buffer kernel datapath
module kernel_window_ctrl #(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 11,
    parameter int K      = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_dv,
    input  logic              i_rx_hs,
    input  logic              i_rx_vs,
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic              o_buf_we,
    output logic              o_shift_en,
    output logic              o_kernel_valid,
    output logic [ADDR_W-1:0] o_center_x,
    output logic [ROW_W-1:0]  o_center_y,
    output logic              o_frame_start,
    output logic              o_line_end,
    output logic [ADDR_W:0]   o_line_len,
    output logic              o_err_len,
    output logic              o_err_ovf,
    output logic [1:0]        o_state
);

    localparam int HALF = K / 2;
    localparam logic [ADDR_W-1:0] COL_KM1  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] COL_HALF = ADDR_W'(HALF);
    localparam logic [ROW_W-1:0]  ROW_KM1  = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_HALF = ROW_W'(HALF);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        H_BLANK    = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_vs_d;
    logic                r_dv_d;
    logic [ADDR_W:0]     r_cnt;     // pixels seen in the current line, saturating
    logic [ROW_W-1:0]    r_row;

    // Lines are delimited by dv alone; hsync is deliberately ignored.
    logic w_unused;
    assign w_unused = i_rx_hs;

    logic              w_vs_rise;
    logic              w_line_end;
    logic              w_pix;
    logic              w_line_start;
    logic [ADDR_W:0]   w_cnt_cur;
    logic [ADDR_W:0]   w_cnt_next;
    logic [ROW_W-1:0]  w_row_cur;
    logic              w_ovf_pix;
    logic [ADDR_W-1:0] w_col;
    logic              w_kv;

    // A vs rise restarts the frame first, so a pixel in the same cycle is col 0 of row 0.
    assign w_vs_rise    = i_rx_vs & ~r_vs_d;
    assign w_line_end   = (r_state == ACTIVE) & r_dv_d & ~i_rx_dv & ~w_vs_rise;
    assign w_pix        = i_rx_dv & ((r_state != WAIT_FRAME) | w_vs_rise);
    assign w_line_start = w_vs_rise | (r_state != ACTIVE);
    assign w_cnt_cur    = w_line_start ? '0 : r_cnt;
    assign w_cnt_next   = (&w_cnt_cur) ? w_cnt_cur : w_cnt_cur + 1'b1;
    assign w_row_cur    = w_vs_rise ? '0 : r_row;
    assign w_ovf_pix    = w_cnt_cur[ADDR_W];
    assign w_col        = w_ovf_pix ? {ADDR_W{1'b1}} : w_cnt_cur[ADDR_W-1:0];
    assign w_kv         = w_pix & ~w_ovf_pix & (w_col >= COL_KM1) & (w_row_cur >= ROW_KM1);
    assign o_state      = r_state;

    // Sequencer FSM with all outputs registered one cycle after the sampled pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= WAIT_FRAME;
            r_vs_d         <= 1'b0;
            r_dv_d         <= 1'b0;
            r_cnt          <= '0;
            r_row          <= '0;
            o_buf_addr     <= '0;
            o_buf_we       <= 1'b0;
            o_shift_en     <= 1'b0;
            o_kernel_valid <= 1'b0;
            o_center_x     <= '0;
            o_center_y     <= '0;
            o_frame_start  <= 1'b0;
            o_line_end     <= 1'b0;
            o_line_len     <= '0;
            o_err_len      <= 1'b0;
            o_err_ovf      <= 1'b0;
        end else begin
            r_vs_d         <= i_rx_vs;
            r_dv_d         <= i_rx_dv;
            o_frame_start  <= w_vs_rise;
            o_line_end     <= w_line_end;
            o_buf_we       <= w_pix;
            o_shift_en     <= w_pix;
            o_kernel_valid <= w_kv;

            if (w_vs_rise) begin
                r_state   <= H_BLANK;
                r_row     <= '0;
                r_cnt     <= '0;
                o_err_len <= 1'b0;
                o_err_ovf <= 1'b0;
            end else if (w_line_end) begin
                r_state    <= H_BLANK;
                o_line_len <= r_cnt;
                if ((r_row != '0) && (r_cnt != o_line_len))
                    o_err_len <= 1'b1;
                if (~&r_row)
                    r_row <= r_row + 1'b1;
            end

            // Pixel handling follows frame restart so it sees the cleared position.
            if (w_pix) begin
                r_state    <= ACTIVE;
                o_buf_addr <= w_col;
                r_cnt      <= w_cnt_next;
                if (w_ovf_pix)
                    o_err_ovf <= 1'b1;
            end

            if (w_kv) begin
                o_center_x <= w_col - COL_HALF;
                o_center_y <= w_row_cur - ROW_HALF;
            end
        end
    end

endmodule
